gate_test_sequencer: RTL and testbench



---
 rtl/gate_test_pkg.sv | 17 +
 rtl/switch_debounce.sv | 39 +++
 rtl/gate_test_sequencer.sv | 120 ++++++++++++
 tb/tb_gate_test_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gate_test_pkg.sv
// Shared constants and state type for the 2-input gate self-test sequencer.
package gate_test_pkg;

  localparam int unsigned STEP_W = 2;

  // Truth tables indexed by step k = {In1,In2}
  localparam logic [3:0] AND_MASK = 4'b1000;
  localparam logic [3:0] OR_MASK  = 4'b1110;
  localparam logic [3:0] XOR_MASK = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer plus stability counter; level follows the raw switch
// only after it has differed from the current level for DEBOUNCE_LIMIT clocks.
module switch_debounce #(
  parameter int unsigned DEBOUNCE_LIMIT = 250_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any return to the accepted level restarts the stability count
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_LIMIT - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Steps a 2-input gate through all four input vectors on a debounced start
// press, samples its output at the end of each dwell and reports pass/fail.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES   = 12_500_000,
  parameter int unsigned DEBOUNCE_LIMIT = 250_000,
  parameter logic [3:0]  EXPECT_MASK    = AND_MASK
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_Start,
  input  logic              i_Gate_Out,
  output logic              o_Gate_In1,
  output logic              o_Gate_In2,
  output logic [STEP_W-1:0] o_Step,
  output logic              o_Busy,
  output logic              o_Pass,
  output logic              o_Fail,
  output logic [STEP_W-1:0] o_Fail_Step
);

  localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);

  state_t              state, state_n;
  logic [STEP_W-1:0]   step_n;
  logic [DWELL_W-1:0]  dwell, dwell_n;
  logic                flag, flag_n;
  logic [STEP_W-1:0]   fail_step_n;
  logic                pass_n, fail_n;
  logic                level, level_q;
  logic                start_evt;
  logic                sample_bad;

  switch_debounce #(
    .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
  ) u_debounce (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .raw  (i_Start),
    .level(level)
  );

  assign start_evt = level & ~level_q;

  // Next-state and result bookkeeping
  always_comb begin
    state_n     = state;
    step_n      = o_Step;
    dwell_n     = dwell;
    flag_n      = flag;
    fail_step_n = o_Fail_Step;
    pass_n      = o_Pass;
    fail_n      = o_Fail;
    sample_bad  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_evt) begin
          state_n     = RUN;
          step_n      = '0;
          dwell_n     = '0;
          flag_n      = 1'b0;
          fail_step_n = '0;
          pass_n      = 1'b0;
          fail_n      = 1'b0;
        end
      end
      RUN: begin
        if (dwell == DWELL_W'(DWELL_CYCLES - 1)) begin
          sample_bad = (i_Gate_Out != EXPECT_MASK[o_Step]);
          // Only the first mismatching step is recorded
          if (sample_bad && !flag) begin
            flag_n      = 1'b1;
            fail_step_n = o_Step;
          end
          if (o_Step == STEP_W'(3)) begin
            state_n = DONE;
            pass_n  = ~flag_n;
            fail_n  = flag_n;
          end else begin
            step_n  = o_Step + STEP_W'(1);
            dwell_n = '0;
          end
        end else begin
          dwell_n = dwell + DWELL_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state       <= IDLE;
      o_Step      <= '0;
      dwell       <= '0;
      flag        <= 1'b0;
      o_Fail_Step <= '0;
      o_Pass      <= 1'b0;
      o_Fail      <= 1'b0;
      o_Busy      <= 1'b0;
      o_Gate_In1  <= 1'b0;
      o_Gate_In2  <= 1'b0;
      level_q     <= 1'b0;
    end else begin
      state       <= state_n;
      o_Step      <= step_n;
      dwell       <= dwell_n;
      flag        <= flag_n;
      o_Fail_Step <= fail_step_n;
      o_Pass      <= pass_n;
      o_Fail      <= fail_n;
      o_Busy      <= (state_n == RUN);
      o_Gate_In1  <= (state_n == RUN) & step_n[1];
      o_Gate_In2  <= (state_n == RUN) & step_n[0];
      level_q     <= level;
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Scoreboard bench: each start press queues the expected run outcome and a
// negedge monitor checks vectors, dwell lengths and results as runs complete.
module tb_gate_test_sequencer;
  import gate_test_pkg::*;

  localparam int DWELL = 4;
  localparam int DEB   = 3;
  localparam int LAT   = 2 + DEB + 1;

  typedef struct {
    int          start_cyc;
    logic        pass;
    logic        fail;
    logic [1:0]  fail_step;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] tt;
  logic       gate_out;
  logic       in1, in2, busy, pass, fail;
  logic [1:0] step, fail_step;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Gate under test modelled as an arbitrary truth table indexed by {In1,In2}
  assign gate_out = tt[{in1, in2}];

  gate_test_sequencer #(
    .DWELL_CYCLES  (DWELL),
    .DEBOUNCE_LIMIT(DEB),
    .EXPECT_MASK   (AND_MASK)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Start    (start),
    .i_Gate_Out (gate_out),
    .o_Gate_In1 (in1),
    .o_Gate_In2 (in2),
    .o_Step     (step),
    .o_Busy     (busy),
    .o_Pass     (pass),
    .o_Fail     (fail),
    .o_Fail_Step(fail_step)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference outcome: compare each step's gate output with the AND table
  function automatic exp_t model(input logic [3:0] t, input int s);
    exp_t e;
    e.start_cyc = s;
    e.fail      = 1'b0;
    e.fail_step = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (t[k] != AND_MASK[k] && !e.fail) begin
        e.fail      = 1'b1;
        e.fail_step = 2'(k);
      end
    end
    e.pass = ~e.fail;
    return e;
  endfunction

  task automatic press(input int hold, input bit expect_run);
    @(posedge clk); #1;
    start = 1'b1;
    if (expect_run) sbq.push_back(model(tt, cyc + LAT));
    repeat (hold) @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in1"}, int'(in1), 0);
    chk({tag, "_in2"}, int'(in2), 0);
    chk({tag, "_step"}, int'(step), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_fail"}, int'(fail), 0);
    chk({tag, "_fail_step"}, int'(fail_step), 0);
  endtask

  // Monitor: tracks each busy window and pops the scoreboard when it ends
  logic busy_q = 1'b0;
  bit   in_run = 1'b0;
  int   run_len = 0;
  exp_t cur;

  always @(negedge clk) begin
    if (rst) begin
      in_run = 1'b0;
      busy_q = 1'b0;
    end else begin
      if (busy && !busy_q) begin
        in_run  = 1'b1;
        run_len = 0;
        if (sbq.size() == 0) begin
          chk("unexpected_run", 1, 0);
        end else begin
          chk("start_latency", cyc, sbq[0].start_cyc);
          chk("restart_pass_clear", int'(pass), 0);
          chk("restart_fail_clear", int'(fail), 0);
          chk("restart_fail_step_clear", int'(fail_step), 0);
        end
      end
      if (busy) begin
        chk("vector", int'({in1, in2}), run_len / DWELL);
        chk("step", int'(step), run_len / DWELL);
        run_len++;
      end else begin
        chk("idle_inputs", int'({in1, in2}), 0);
      end
      if (!busy && busy_q && in_run) begin
        in_run = 1'b0;
        if (sbq.size() != 0) begin
          cur = sbq.pop_front();
          chk("run_length", run_len, 4 * DWELL);
          chk("pass", int'(pass), int'(cur.pass));
          chk("fail", int'(fail), int'(cur.fail));
          chk("fail_step", int'(fail_step), int'(cur.fail_step));
        end
      end
      busy_q = busy;
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    tt    = AND_MASK;
    idle(3);
    rst = 1'b0;
    idle(20);
    check_reset_outputs("reset_idle");

    // Clean press with a correct AND gate
    press(10, 1'b1);
    idle(40);

    // Bouncy press: 2-cycle pulses never satisfy the stability count
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      idle(2);
      start = 1'b0;
      idle(2);
    end
    press(10, 1'b1);
    idle(40);

    // Stuck-at gates
    tt = 4'b1111;
    press(6, 1'b1);
    idle(40);
    tt = 4'b0000;
    press(6, 1'b1);
    idle(40);

    // Second press while running is ignored
    tt = AND_MASK;
    press(6, 1'b1);
    idle(7);
    press(6, 1'b0);
    idle(40);

    // Restart from DONE: failing run, then results cleared and a passing run
    tt = XOR_MASK;
    press(6, 1'b1);
    idle(40);
    tt = AND_MASK;
    press(6, 1'b1);
    idle(40);

    // Reset during step 2, mid-dwell
    press(6, 1'b1);
    idle(9);
    chk("pre_reset_step", int'(step), 2);
    rst = 1'b1;
    void'(sbq.pop_back());
    idle(1);
    check_reset_outputs("mid_run_reset");
    rst = 1'b0;
    idle(10);
    press(6, 1'b1);
    idle(40);

    // Random gate truth tables
    for (int i = 0; i < 8; i++) begin
      tt = 4'($urandom_range(0, 15));
      press(6 + int'($urandom_range(0, 4)), 1'b1);
      idle(40);
    end

    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
